// File: rtl/nibble_serial_adder.sv
// Nibble-serial add/subtract sequencer: one 4-bit ripple slice walks W-bit
// operands LSB nibble first, chaining the carry through a register.
module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic         cin,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] S,
  output logic         cout,
  output logic         ovf,
  output logic [1:0]   dbg_state
);

  // Handshake: start is accepted on a rising edge whenever busy=0 (IDLE or
  // DONE); done is a one-cycle pulse and never overlaps busy.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_next;
  logic [W-1:0]   opa, opb, p, p_next;
  logic           cr;
  logic [KW-1:0]  k;
  logic [3:0]     slice_x, slice_y, slice_s;
  logic [4:0]     chain;
  logic           slice_c;
  logic           last;
  logic           accept;

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;
  assign accept    = start && (state != RUN);
  assign last      = (k == KW'(NIBBLES - 1));

  // Single 4-bit ripple slice operating on nibble k.
  always_comb begin
    slice_x  = opa[{k, 2'b00} +: 4];
    slice_y  = opb[{k, 2'b00} +: 4];
    chain    = '0;
    slice_s  = '0;
    chain[0] = cr;
    for (int i = 0; i < 4; i++) begin
      slice_s[i]   = slice_x[i] ^ slice_y[i] ^ chain[i];
      chain[i+1]   = (slice_x[i] & slice_y[i]) | (slice_x[i] & chain[i]) |
                     (slice_y[i] & chain[i]);
    end
    slice_c = chain[4];
    p_next  = p;
    p_next[{k, 2'b00} +: 4] = slice_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa  <= '0;
      opb  <= '0;
      p    <= '0;
      cr   <= 1'b0;
      k    <= '0;
      S    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      // Subtract is A + ~B + 1: invert B at latch time, seed carry with 1.
      opa <= A;
      opb <= sub ? ~B : B;
      cr  <= sub ? 1'b1 : cin;
      k   <= '0;
    end else if (state == RUN) begin
      p  <= p_next;
      cr <= slice_c;
      k  <= last ? '0 : k + KW'(1);
      if (last) begin
        S    <= p_next;
        cout <= slice_c;
        ovf  <= (opa[W-1] == opb[W-1]) && (p_next[W-1] != opa[W-1]);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: NIBBLES=4 main instance plus a
// NIBBLES=2 instance for the narrow-width case.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] s;
  logic [1:0]  st;

  logic        start2 = 1'b0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic        busy2, done2, cout2, ovf2;
  logic [7:0]  s2;
  logic [1:0]  st2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .cin(cin),
    .A(a), .B(b), .busy(busy), .done(done), .S(s), .cout(cout), .ovf(ovf),
    .dbg_state(st)
  );

  nibble_serial_adder #(.NIBBLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .sub(1'b0), .cin(1'b0),
    .A(a2), .B(b2), .busy(busy2), .done(done2), .S(s2), .cout(cout2), .ovf(ovf2),
    .dbg_state(st2)
  );

  // Drive one operation on the 4-nibble instance and return cycles from the
  // accepting edge to done (-1 if done never arrives).
  task automatic drive_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic cv, output int lat);
    bit seen;
    @(negedge clk);
    a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (done) begin
          lat = i;
          seen = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, cout, ovf} !== 4'b0000 || s !== 16'h0000 || st !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b S=%h cout=%b ovf=%b st=%0d expected all 0",
               busy, done, s, cout, ovf, st);
    end
    checks++;
    if ({busy2, done2} !== 2'b00 || s2 !== 8'h00 || st2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs2: busy=%b done=%b S=%h expected 0", busy2, done2, s2);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add_basic();
    int lat;
    drive_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_latency: got %0d expected 4", lat);
    end
    checks++;
    if (s !== 16'h5555 || cout !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_basic: S=%h cout=%b ovf=%b busy=%b expected 5555 0 0 0", s, cout, ovf, busy);
    end
  endtask

  task automatic test_carry();
    int lat;
    drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4 || s !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL carry_wrap: lat=%0d S=%h cout=%b ovf=%b expected 4 0000 1 0", lat, s, cout, ovf);
    end
    drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 4 || s !== 16'h0001 || cout !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL carry_cin: lat=%0d S=%h cout=%b ovf=%b expected 4 0001 1 0", lat, s, cout, ovf);
    end
  endtask

  task automatic test_signed();
    int lat;
    drive_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if (s !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL signed_add_ovf: S=%h cout=%b ovf=%b expected 8000 0 1", s, cout, ovf);
    end
    drive_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
    checks++;
    if (s !== 16'hFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: S=%h cout=%b ovf=%b expected FFFE 0 0", s, cout, ovf);
    end
    drive_op(16'h8000, 16'h0001, 1'b1, 1'b0, lat);
    checks++;
    if (lat !== 4 || s !== 16'h7FFF || cout !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: lat=%0d S=%h cout=%b ovf=%b expected 4 7FFF 1 1", lat, s, cout, ovf);
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    int  lat;
    bit  seen;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL accept_busy: busy=%b done=%b expected 1 0", busy, done);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; cin = 1'b1; start = 1'b1;
    checks++;
    if (s !== 16'h7FFF || cout !== 1'b1) begin
      errors++;
      $display("FAIL hold_during_run: S=%h cout=%b expected 7FFF 1", s, cout);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || st !== 2'd1) begin
      errors++;
      $display("FAIL ignored_start: busy=%b done=%b st=%0d expected 1 0 1", busy, done, st);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || s !== 16'h3333 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL on_schedule: done=%b busy=%b S=%h cout=%b ovf=%b expected 1 0 3333 0 0",
               done, busy, s, cout, ovf);
    end
    a = 16'h0001; b = 16'h0002; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", busy, done);
    end
    lat = -1;
    seen = 1'b0;
    for (int i = 2; i <= 20; i++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (done) begin
          lat = i;
          seen = 1'b1;
        end
      end
    end
    checks++;
    if (lat !== 5 || s !== 16'h0003) begin
      errors++;
      $display("FAIL b2b_result: cycles_after_done=%0d S=%h expected 5 0003", lat, s);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit saw_done;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, ovf} !== 4'b0000 || s !== 16'h0000 || st !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b S=%h cout=%b ovf=%b expected all 0",
               busy, done, s, cout, ovf);
    end
    saw_done = 1'b0;
    @(posedge clk); #1;
    if (done) saw_done = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_done_after_abort: saw_done=%b busy=%b expected 0 0", saw_done, busy);
    end
    drive_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4 || s !== 16'h1000 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_op: lat=%0d S=%h cout=%b ovf=%b expected 4 1000 0 0", lat, s, cout, ovf);
    end
  endtask

  task automatic test_nibbles2();
    int lat;
    bit seen;
    @(negedge clk);
    a2 = 8'hFF; b2 = 8'hFF; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = -1;
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (done2) begin
          lat = i;
          seen = 1'b1;
        end
      end
    end
    checks++;
    if (lat !== 2 || s2 !== 8'hFE || cout2 !== 1'b1 || ovf2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL nibbles2_add: lat=%0d S=%h cout=%b ovf=%b busy=%b expected 2 FE 1 0 0",
               lat, s2, cout2, ovf2, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry();
    test_signed();
    test_ignore_and_back_to_back();
    test_reset_mid_run();
    test_nibbles2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
